rdid_reader: RTL and testbench

Consumes the debounced RDID request from the debounce stage and runs one SPI Read-Identification transaction per press: sends the RDID opcode to the serial flash, shifts in the 3-byte JEDEC ID, and presents it with a one-cycle valid strobe. Sits directly downstream of the debounce block (`get_rdid_debounce`) and drives the flash SPI pins. SPI mode 0, master only, single outstanding transaction.

---
 rtl/rdid_reader.sv | 209 ++++++++++++++++++++
 tb/tb_rdid_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rdid_reader.sv
`default_nettype none
//============================================================================
// Module   : rdid_reader
// Purpose  : Runs one SPI (mode 0, master) Read-Identification transaction
//            per rising edge of the debounced request. Shifts out the RDID
//            opcode, shifts in the 3-byte JEDEC ID and presents it with a
//            one-cycle valid strobe.
// Ports    : clk               - system clock, rising edge
//            rst               - asynchronous reset, active-low
//            get_rdid_debounce - debounced request level
//            spi_miso          - flash serial data out
//            spi_cs_n          - flash chip select, active-low
//            spi_sclk          - SPI clock, idles low
//            spi_mosi          - flash serial data in
//            id_data[23:0]     - last ID read {manufacturer, type, capacity}
//            id_valid          - one-cycle strobe, id_data new this cycle
//            busy              - high from trigger through the id_valid cycle
// Params   : CLK_DIV (1..255) - clk cycles per SCLK half-period
//            CMD              - opcode shifted out MSB first
// Revision : 1.0 - initial release
//============================================================================
module rdid_reader #(
   parameter int unsigned CLK_DIV = 4,
   parameter logic [7:0]  CMD     = 8'h9F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        get_rdid_debounce,
   input  logic        spi_miso,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic [23:0] id_data,
   output logic        id_valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Divider counts 0..CLK_DIV-1 within each phase; 8 bits covers 255.
   localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [5:0] c_BIT_LAST = 6'd31;
   localparam logic [5:0] c_CMD_BITS = 6'd8;

   state_t      r_state, w_state_nx;
   logic [7:0]  r_div,   w_div_nx;
   logic [5:0]  r_bit,   w_bit_nx;
   logic [23:0] r_shift, w_shift_nx;
   logic        r_cs_n,  w_cs_n_nx;
   logic        r_sclk,  w_sclk_nx;
   logic        r_mosi,  w_mosi_nx;
   logic [23:0] r_id,    w_id_nx;
   logic        r_valid, w_valid_nx;
   logic        r_busy,  w_busy_nx;
   logic        r_req_d;

   logic        w_trigger;
   logic        w_div_end;
   logic [5:0]  w_bit_inc;
   logic [2:0]  w_cmd_idx;
   logic        w_mosi_next;

   // Previous request level resets to 1, so a request already high when
   // reset releases does not look like a fresh press.
   assign w_trigger = get_rdid_debounce & ~r_req_d;
   assign w_div_end = (r_div == c_DIV_LAST);
   assign w_bit_inc = r_bit + 6'd1;

   // Data for the slot that follows the current one: opcode bits first,
   // then zeros while the ID streams back.
   assign w_cmd_idx   = 3'd7 - w_bit_inc[2:0];
   assign w_mosi_next = (w_bit_inc < c_CMD_BITS) ? CMD[w_cmd_idx] : 1'b0;

   //------------------------------------------------------------------------
   // Next-state and next-output logic
   //------------------------------------------------------------------------
   always_comb begin
      w_state_nx = r_state;
      w_div_nx   = r_div;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_cs_n_nx  = r_cs_n;
      w_sclk_nx  = r_sclk;
      w_mosi_nx  = r_mosi;
      w_id_nx    = r_id;
      w_valid_nx = 1'b0;
      w_busy_nx  = r_busy;

      unique case (r_state)
         ST_IDLE: begin
            w_cs_n_nx = 1'b1;
            w_sclk_nx = 1'b0;
            if (w_trigger) begin
               w_state_nx = ST_SETUP;
               w_busy_nx  = 1'b1;
               w_cs_n_nx  = 1'b0;
               w_mosi_nx  = CMD[7];
               w_div_nx   = 8'd0;
            end
         end

         ST_SETUP: begin
            if (w_div_end) begin
               // First rising SCLK edge; slot 0 carries an opcode bit, so
               // its MISO sample is not kept.
               w_state_nx = ST_SHIFT;
               w_div_nx   = 8'd0;
               w_bit_nx   = 6'd0;
               w_sclk_nx  = 1'b1;
            end else begin
               w_div_nx = r_div + 8'd1;
            end
         end

         ST_SHIFT: begin
            if (w_div_end) begin
               w_div_nx = 8'd0;
               if (r_sclk) begin
                  // Falling edge: slave sees a full half-period of setup.
                  w_sclk_nx = 1'b0;
                  w_mosi_nx = w_mosi_next;
               end else if (r_bit == c_BIT_LAST) begin
                  w_state_nx = ST_HOLD;
               end else begin
                  // Rising edge of the next slot: capture MISO, keeping
                  // only the slots after the opcode.
                  w_sclk_nx = 1'b1;
                  w_bit_nx  = w_bit_inc;
                  if (w_bit_inc >= c_CMD_BITS) begin
                     w_shift_nx = {r_shift[22:0], spi_miso};
                  end
               end
            end else begin
               w_div_nx = r_div + 8'd1;
            end
         end

         ST_HOLD: begin
            if (w_div_end) begin
               w_state_nx = ST_DONE;
               w_div_nx   = 8'd0;
               w_cs_n_nx  = 1'b1;
               w_id_nx    = r_shift;
               w_valid_nx = 1'b1;
            end else begin
               w_div_nx = r_div + 8'd1;
            end
         end

         ST_DONE: begin
            w_state_nx = ST_IDLE;
            w_busy_nx  = 1'b0;
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_cs_n_nx  = 1'b1;
            w_sclk_nx  = 1'b0;
            w_busy_nx  = 1'b0;
         end
      endcase
   end

   //------------------------------------------------------------------------
   // State and output registers
   //------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_div   <= 8'd0;
         r_bit   <= 6'd0;
         r_shift <= 24'd0;
         r_cs_n  <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_id    <= 24'd0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_req_d <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_div   <= w_div_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_cs_n  <= w_cs_n_nx;
         r_sclk  <= w_sclk_nx;
         r_mosi  <= w_mosi_nx;
         r_id    <= w_id_nx;
         r_valid <= w_valid_nx;
         r_busy  <= w_busy_nx;
         r_req_d <= get_rdid_debounce;
      end
   end

   assign spi_cs_n = r_cs_n;
   assign spi_sclk = r_sclk;
   assign spi_mosi = r_mosi;
   assign id_data  = r_id;
   assign id_valid = r_valid;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rdid_reader.sv
`default_nettype none
//============================================================================
// Module   : tb_rdid_reader
// Purpose  : Self-checking bench for rdid_reader. Instance A uses default
//            parameters, instance B uses CLK_DIV=1. Each has a flash model
//            that drives its ID on falling SCLK edges and decodes MOSI.
//            Expected IDs are queued at each press and popped on id_valid.
// Revision : 1.0 - initial release
//============================================================================
module tb_rdid_reader;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic a_req = 1'b0, a_miso = 1'b1, a_cs_n, a_sclk, a_mosi, a_valid, a_busy;
   logic b_req = 1'b0, b_miso = 1'b1, b_cs_n, b_sclk, b_mosi, b_valid, b_busy;
   logic [23:0] a_id, b_id;

   rdid_reader dut (
      .clk(clk), .rst(rst), .get_rdid_debounce(a_req), .spi_miso(a_miso),
      .spi_cs_n(a_cs_n), .spi_sclk(a_sclk), .spi_mosi(a_mosi),
      .id_data(a_id), .id_valid(a_valid), .busy(a_busy)
   );

   rdid_reader #(.CLK_DIV(1), .CMD(8'h9F)) dut_div1 (
      .clk(clk), .rst(rst), .get_rdid_debounce(b_req), .spi_miso(b_miso),
      .spi_cs_n(b_cs_n), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
      .id_data(b_id), .id_valid(b_valid), .busy(b_busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- flash models ----------------
   logic [23:0] a_model_id = 24'h0, b_model_id = 24'h0;
   int          a_rises = 0, b_rises = 0;
   logic [31:0] a_mosi_sh = 0, b_mosi_sh = 0;

   always @(negedge a_cs_n) begin a_rises = 0; a_mosi_sh = 0; end
   always @(negedge b_cs_n) begin b_rises = 0; b_mosi_sh = 0; end
   always @(posedge a_sclk) begin a_rises++; a_mosi_sh = {a_mosi_sh[30:0], a_mosi}; end
   always @(posedge b_sclk) begin b_rises++; b_mosi_sh = {b_mosi_sh[30:0], b_mosi}; end
   // ID bits come out after the 8th rising edge; ones during the opcode.
   always @(negedge a_sclk)
      a_miso = (a_rises >= 8 && a_rises < 32) ? a_model_id[31 - a_rises] : 1'b1;
   always @(negedge b_sclk)
      b_miso = (b_rises >= 8 && b_rises < 32) ? b_model_id[31 - b_rises] : 1'b1;

   // ---------------- scoreboards ----------------
   logic [23:0] a_q[$], b_q[$];
   logic [23:0] a_exp, b_exp;
   int a_vcnt = 0, b_vcnt = 0;

   always @(negedge clk) begin
      if (a_valid === 1'b1) begin
         a_vcnt++;
         check("a_valid_expected", 32'(a_q.size() != 0), 1);
         if (a_q.size() != 0) begin
            a_exp = a_q.pop_front();
            check("a_id_data", 32'(a_id), 32'(a_exp));
         end
      end
      if (b_valid === 1'b1) begin
         b_vcnt++;
         check("b_valid_expected", 32'(b_q.size() != 0), 1);
         if (b_q.size() != 0) begin
            b_exp = b_q.pop_front();
            check("b_id_data", 32'(b_id), 32'(b_exp));
         end
      end
   end

   // ---------------- accessors ----------------
   function automatic logic f_cs(input bit i);    return i ? b_cs_n  : a_cs_n;  endfunction
   function automatic logic f_sclk(input bit i);  return i ? b_sclk  : a_sclk;  endfunction
   function automatic logic f_busy(input bit i);  return i ? b_busy  : a_busy;  endfunction
   function automatic logic f_valid(input bit i); return i ? b_valid : a_valid; endfunction
   function automatic int   f_rises(input bit i); return i ? b_rises : a_rises; endfunction
   function automatic int   f_vcnt(input bit i);  return i ? b_vcnt  : a_vcnt;  endfunction
   function automatic logic [31:0] f_msh(input bit i); return i ? b_mosi_sh : a_mosi_sh; endfunction

   task automatic set_req(input bit i, input logic v);
      if (i) b_req = v; else a_req = v;
   endtask

   // mode 0: pulse request, 1: toggle during transfer, 2: hold high
   task automatic run_xact(input bit i, input logic [23:0] id, input int cd, input int mode);
      int low;
      int first_rise;
      int v0;
      v0 = f_vcnt(i);
      if (i) begin b_model_id = id; b_q.push_back(id); end
      else   begin a_model_id = id; a_q.push_back(id); end
      set_req(i, 1'b1);
      @(negedge clk);
      check("trig_cs_low", 32'(f_cs(i)), 0);
      check("trig_busy", 32'(f_busy(i)), 1);
      if (mode == 0) set_req(i, 1'b0);
      low = 0;
      first_rise = -1;
      while (f_cs(i) === 1'b0 && low < 66 * cd + 20) begin
         if (first_rise < 0 && f_sclk(i) === 1'b1) first_rise = low;
         if (mode == 1 && low >= 40 && low <= 121) set_req(i, (low % 40) != 0);
         if (mode == 1 && low == 122) set_req(i, 1'b0);
         low++;
         @(negedge clk);
      end
      check("cs_low_cycles", low, 66 * cd);
      check("first_sclk_rise", first_rise, cd);
      check("done_valid_busy", {f_valid(i), f_busy(i)}, 2'b11);
      check("sclk_rises", f_rises(i), 32);
      check("mosi_stream", f_msh(i), 32'h9F00_0000);
      @(negedge clk);
      check("after_done", {f_valid(i), f_busy(i), f_cs(i)}, 3'b001);
      @(negedge clk);
      check("valid_count", f_vcnt(i), v0 + 1);
   endtask

   localparam logic [28:0] c_RST_VEC = {1'b1, 4'b0000, 24'h0};

   initial begin
      int cnt;
      // Reset state
      repeat (3) @(negedge clk);
      check("a_reset_vals", {a_cs_n, a_sclk, a_mosi, a_valid, a_busy, a_id}, c_RST_VEC);
      check("b_reset_vals", {b_cs_n, b_sclk, b_mosi, b_valid, b_busy, b_id}, c_RST_VEC);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Basic read at default divider
      run_xact(0, 24'h20BA19, 4, 0);
      check("a_id_hold", 32'(a_id), 32'h20BA19);

      // Request toggled during a transfer: one read only
      run_xact(0, 24'h20BA19, 4, 1);
      cnt = 0;
      repeat (300) begin @(negedge clk); if (a_cs_n === 1'b0) cnt++; end
      check("toggle_no_queue", cnt, 0);

      // Request held high: one read, then re-press reads new value
      run_xact(0, 24'h20BA19, 4, 2);
      cnt = 0;
      repeat (1730) begin @(negedge clk); if (a_cs_n === 1'b0) cnt++; end
      check("hold_no_retrigger", cnt, 0);
      a_req = 1'b0;
      repeat (3) @(negedge clk);
      run_xact(0, 24'hEF4018, 4, 0);

      // Asynchronous reset during slot 12
      a_model_id = 24'h777777;
      a_req = 1'b1;
      @(negedge clk);
      a_req = 1'b0;
      cnt = 0;
      while (a_rises != 13 && cnt < 400) begin @(negedge clk); cnt++; end
      check("reach_bit12", a_rises, 13);
      #2 rst = 1'b0;
      #1 check("a_async_reset", {a_cs_n, a_sclk, a_mosi, a_valid, a_busy, a_id}, c_RST_VEC);
      check("b_async_reset", {b_cs_n, b_sclk, b_mosi, b_valid, b_busy, b_id}, c_RST_VEC);
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (300) begin @(negedge clk); if (a_cs_n === 1'b0) cnt++; end
      check("abort_no_activity", cnt, 0);
      check("abort_id_zero", 32'(a_id), 0);
      run_xact(0, 24'h5A3C96, 4, 0);

      // CLK_DIV = 1 instance
      run_xact(1, 24'hC22017, 1, 0);

      // Request high through reset release: no trigger until re-pressed
      a_req = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (20) begin @(negedge clk); if (a_cs_n === 1'b0 || a_busy === 1'b1) cnt++; end
      check("held_through_reset", cnt, 0);
      a_req = 1'b0;
      repeat (3) @(negedge clk);
      run_xact(0, 24'h8899AA, 4, 0);

      repeat (5) @(negedge clk);
      check("a_queue_empty", a_q.size(), 0);
      check("b_queue_empty", b_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
